// File: rtl/zeroriscy_mmult_seq.sv
// Dot-product job sequencer feeding the EX-stage MMULT unit.
// Define MMULT_SEQ_PERF_EN to add the busy-cycle counter on perf_cycles_o.
module zeroriscy_mmult_seq #(
  parameter int EXEC_LAT = 4,
  parameter int MAX_LEN  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] base_a_i,
  input  logic [31:0] base_b_i,
  input  logic [6:0]  len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] result_o,
  output logic        data_req_o,
  output logic [31:0] data_addr_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        mmult_en_o,
  output logic [2:0]  mmult_operator_o,
  output logic [6:0]  mmult_param_o,
  output logic [31:0] mmult_operand_addr_o,
  output logic [31:0] mmult_operand_data_o,
  output logic        mmult_stall_o,
  input  logic [31:0] mmult_result_i,
  output logic [31:0] perf_cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_A,
    S_WAIT_A,
    S_REQ_B,
    S_WAIT_B,
    S_EXEC,
    S_LAT,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_NONE   = 3'b000;
  localparam logic [2:0] OP_LOAD_A = 3'b001;
  localparam logic [2:0] OP_LOAD_B = 3'b010;
  localparam logic [2:0] OP_EXEC   = 3'b011;
  localparam logic [3:0] LAT_INIT  = 4'(EXEC_LAT - 1);
  localparam logic [7:0] MAX_L     = 8'(MAX_LEN);

  state_e      state_q, state_d;
  logic [6:0]  k_q, k_d;
  logic [6:0]  len_q, len_d;
  logic [31:0] base_a_q, base_a_d;
  logic [31:0] base_b_q, base_b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;
  logic        en_q, en_d;
  logic [2:0]  op_q, op_d;
  logic [6:0]  param_q, param_d;
  logic [31:0] opaddr_q, opaddr_d;
  logic [31:0] opdata_q, opdata_d;

  logic        in_a;
  logic        req;
  logic [31:0] cur_addr;
  logic        unused_bits;

  assign unused_bits = ^{base_a_i[1:0], base_b_i[1:0]};

  assign in_a = (state_q == S_REQ_A) || (state_q == S_WAIT_A);
  assign req  = (state_q == S_REQ_A) || (state_q == S_REQ_B);
  assign cur_addr = (in_a ? base_a_q : base_b_q)
                  + {23'd0, k_q, 2'b00};

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    len_d    = len_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    result_d = result_q;
    en_d     = 1'b0;
    op_d     = OP_NONE;
    param_d  = '0;
    opaddr_d = '0;
    opdata_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          k_d   = '0;
          if (len_i == 7'd0) begin
            result_d = '0;
            state_d  = S_DONE;
          end else if ({1'b0, len_i} > MAX_L) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            len_d    = len_i;
            base_a_d = {base_a_i[31:2], 2'b00};
            base_b_d = {base_b_i[31:2], 2'b00};
            state_d  = S_REQ_A;
          end
        end
      end
      S_REQ_A: if (data_gnt_i) state_d = S_WAIT_A;
      S_REQ_B: if (data_gnt_i) state_d = S_WAIT_B;
      S_WAIT_A, S_WAIT_B: begin
        if (data_rvalid_i) begin
          if (data_err_i) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            en_d     = 1'b1;
            op_d     = in_a ? OP_LOAD_A : OP_LOAD_B;
            param_d  = k_q;
            opaddr_d = cur_addr;
            opdata_d = data_rdata_i;
            if (in_a) begin
              state_d = S_REQ_B;
            end else if (k_q == len_q - 7'd1) begin
              state_d = S_EXEC;
            end else begin
              k_d     = k_q + 7'd1;
              state_d = S_REQ_A;
            end
          end
        end
      end
      S_EXEC: begin
        en_d    = 1'b1;
        op_d    = OP_EXEC;
        param_d = len_q - 7'd1;
        cnt_d   = LAT_INIT;
        state_d = S_LAT;
      end
      S_LAT: begin
        if (cnt_q == 4'd0) begin
          result_d = mmult_result_i;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      len_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      en_q     <= 1'b0;
      op_q     <= OP_NONE;
      param_q  <= '0;
      opaddr_q <= '0;
      opdata_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      len_q    <= len_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      result_q <= result_d;
      en_q     <= en_d;
      op_q     <= op_d;
      param_q  <= param_d;
      opaddr_q <= opaddr_d;
      opdata_q <= opdata_d;
    end
  end

  assign busy_o               = (state_q != S_IDLE);
  assign done_o               = (state_q == S_DONE);
  assign err_o                = err_q;
  assign result_o             = result_q;
  assign data_req_o           = req;
  assign data_addr_o          = req ? cur_addr : '0;
  assign mmult_en_o           = en_q;
  assign mmult_operator_o     = op_q;
  assign mmult_param_o        = param_q;
  assign mmult_operand_addr_o = opaddr_q;
  assign mmult_operand_data_o = opdata_q;
  assign mmult_stall_o        = busy_o & ~en_q;

`ifdef MMULT_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && start_i) begin
      perf_d = '0;
    end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_zeroriscy_mmult_seq.sv
// Randomized self-checking bench for zeroriscy_mmult_seq.
// Memory responder and expected job behaviour are modelled in the bench.
module tb_zeroriscy_mmult_seq;

  localparam int LAT  = 4;
  localparam int MAXL = 64;
`ifdef MMULT_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst, start_i;
  logic [31:0] base_a_i, base_b_i;
  logic [6:0]  len_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] result_o;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;
  logic        mmult_en_o;
  logic [2:0]  mmult_operator_o;
  logic [6:0]  mmult_param_o;
  logic [31:0] mmult_operand_addr_o, mmult_operand_data_o;
  logic        mmult_stall_o;
  logic [31:0] mmult_result_i, perf_cycles_o;

  zeroriscy_mmult_seq #(.EXEC_LAT(LAT), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .base_a_i(base_a_i), .base_b_i(base_b_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .result_o(result_o),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .mmult_en_o(mmult_en_o), .mmult_operator_o(mmult_operator_o),
    .mmult_param_o(mmult_param_o),
    .mmult_operand_addr_o(mmult_operand_addr_o),
    .mmult_operand_data_o(mmult_operand_data_o),
    .mmult_stall_o(mmult_stall_o),
    .mmult_result_i(mmult_result_i),
    .perf_cycles_o(perf_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] seed;
  logic [2:0]  obs_op[$];
  logic [6:0]  obs_param[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] req_q[$];
  int          done_cyc, done_cnt, stable_bad, stall_bad;
  logic [31:0] res_at_done, res_obs, perf_after;
  logic        err_obs;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  // One job against a modelled single-outstanding memory.
  task automatic run_job(input logic [6:0] len, input logic [31:0] ba,
                         input logic [31:0] bb, input int fdelay,
                         input int err_at, input int ign_at);
    int held = 0;
    int nreq = 0;
    logic pend = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] hold_addr = '0;
    obs_op.delete(); obs_param.delete();
    obs_addr.delete(); obs_data.delete(); req_q.delete();
    done_cyc = -1; done_cnt = 0; stable_bad = 0; stall_bad = 0;
    perf_after = 32'hDEAD_BEEF;
    @(negedge clk);
    start_i = 1'b1; len_i = len; base_a_i = ba; base_b_i = bb;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      start_i  = (c == ign_at);
      len_i    = 7'($urandom_range(1, 20));
      base_a_i = $urandom;
      base_b_i = $urandom;
      if (mmult_en_o) begin
        obs_op.push_back(mmult_operator_o);
        obs_param.push_back(mmult_param_o);
        obs_addr.push_back(mmult_operand_addr_o);
        obs_data.push_back(mmult_operand_data_o);
      end
      if (mmult_stall_o !== (busy_o && !mmult_en_o)) stall_bad++;
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c; res_at_done = mmult_result_i;
          res_obs = result_o; err_obs = err_o;
        end
      end
      if (done_cyc > 0 && c == done_cyc + 1) perf_after = perf_cycles_o;
      data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = $urandom;
      if (pend) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = memf(paddr);
        data_err_i    = (nreq - 1 == err_at);
        pend = 1'b0;
      end
      data_gnt_i = 1'b0;
      if (data_req_o) begin
        if (held > 0 && data_addr_o !== hold_addr) stable_bad++;
        if (held < ((nreq == 0) ? fdelay : 0)) begin
          held++; hold_addr = data_addr_o;
        end else begin
          data_gnt_i = 1'b1; pend = 1'b1; paddr = data_addr_o;
          req_q.push_back(data_addr_o); nreq++; held = 0;
        end
      end
      mmult_result_i = $urandom;
      if (done_cyc > 0 && c >= done_cyc + 3) break;
    end
    start_i = 1'b0; data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0; data_err_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, err_o, data_req_o, mmult_en_o, mmult_stall_o} !== 6'd0
        || result_o !== 0 || data_addr_o !== 0 || mmult_operator_o !== 0
        || mmult_param_o !== 0 || mmult_operand_addr_o !== 0
        || mmult_operand_data_o !== 0 || perf_cycles_o !== 0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b res=%h req=%b en=%b perf=%h expected all 0",
               busy_o, done_o, err_o, result_o, data_req_o, mmult_en_o, perf_cycles_o);
    end
  endtask

  task automatic test_dot_product();
    logic [6:0]  len;
    logic [31:0] ba, bb, ea, exp_perf;
    logic [31:0] exp_addr[$];
    int exp_done;
    bit bad;
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        len = 7'd2; ba = 32'h100; bb = 32'h203;
      end else begin
        len = 7'($urandom_range(1, 8)); ba = $urandom; bb = $urandom;
      end
      seed = $urandom;
      run_job(len, ba, bb, 0, -1, 3);
      exp_addr.delete();
      for (int k = 0; k < int'(len); k++) begin
        exp_addr.push_back({ba[31:2], 2'b00} + 32'(4 * k));
        exp_addr.push_back({bb[31:2], 2'b00} + 32'(4 * k));
      end
      bad = (req_q.size() != exp_addr.size());
      if (!bad) foreach (exp_addr[i]) if (req_q[i] !== exp_addr[i]) bad = 1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL dp_addr it=%0d got %0d reqs (first %h) expected %0d (first %h)",
                 it, req_q.size(), (req_q.size() > 0) ? req_q[0] : 32'h0,
                 exp_addr.size(), exp_addr[0]);
      end
      bad = (obs_op.size() != exp_addr.size() + 1);
      if (!bad) begin
        foreach (exp_addr[i]) begin
          ea = exp_addr[i];
          if (obs_op[i] !== ((i % 2) ? 3'b010 : 3'b001)) bad = 1;
          if (obs_param[i] !== 7'(i / 2)) bad = 1;
          if (obs_addr[i] !== ea || obs_data[i] !== memf(ea)) bad = 1;
        end
        if (obs_op[exp_addr.size()] !== 3'b011) bad = 1;
        if (obs_param[exp_addr.size()] !== len - 7'd1) bad = 1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL dp_strobes it=%0d got %0d strobes expected %0d with LOAD/EXEC fields",
                 it, obs_op.size(), exp_addr.size() + 1);
      end
      exp_done = 4 * int'(len) + 2 + LAT;
      checks++;
      if (done_cyc != exp_done || done_cnt != 1) begin
        errors++;
        $display("FAIL dp_done it=%0d got cycle %0d count %0d expected cycle %0d count 1",
                 it, done_cyc, done_cnt, exp_done);
      end
      checks++;
      if (res_obs !== res_at_done || err_obs !== 1'b0) begin
        errors++;
        $display("FAIL dp_result it=%0d got %h err %b expected %h err 0",
                 it, res_obs, err_obs, res_at_done);
      end
      exp_perf = PERF ? 32'(exp_done) : 32'd0;
      checks++;
      if (perf_after !== exp_perf || stall_bad != 0) begin
        errors++;
        $display("FAIL dp_perf_stall it=%0d got perf %0d stall_bad %0d expected perf %0d stall_bad 0",
                 it, perf_after, stall_bad, exp_perf);
      end
    end
  endtask

  task automatic test_gnt_delay();
    seed = $urandom;
    run_job(7'd2, 32'h1000, 32'h2000, 3, -1, 0);
    checks++;
    if (req_q.size() != 4 || stable_bad != 0 || req_q[0] !== 32'h1000) begin
      errors++;
      $display("FAIL gnt_delay_req got %0d reqs unstable %0d expected 4 reqs unstable 0",
               req_q.size(), stable_bad);
    end
    checks++;
    if (done_cyc != 4 * 2 + 2 + LAT + 3) begin
      errors++;
      $display("FAIL gnt_delay_done got cycle %0d expected %0d", done_cyc, 4 * 2 + 2 + LAT + 3);
    end
  endtask

  task automatic test_len_bounds();
    logic [6:0] lens[3];
    lens[0] = 7'd0; lens[1] = 7'd65; lens[2] = 7'd127;
    seed = $urandom;
    run_job(7'd1, $urandom, $urandom, 0, -1, 0);
    foreach (lens[i]) begin
      run_job(lens[i], $urandom, $urandom, 0, -1, 0);
      checks++;
      if (done_cyc != 1 || done_cnt != 1 || req_q.size() != 0
          || obs_op.size() != 0 || err_obs !== (lens[i] != 0)
          || (lens[i] == 0 && res_obs !== 32'd0)) begin
        errors++;
        $display("FAIL len_bound len=%0d got done %0d reqs %0d strobes %0d err %b res %h",
                 lens[i], done_cyc, req_q.size(), obs_op.size(), err_obs, res_obs);
      end
    end
    seed = $urandom;
    run_job(7'd64, $urandom, $urandom, 0, -1, 0);
    checks++;
    if (done_cyc != 4 * 64 + 2 + LAT || obs_op.size() != 129 || err_obs !== 1'b0
        || obs_param[128] !== 7'd63) begin
      errors++;
      $display("FAIL len_max got done %0d strobes %0d err %b expected %0d 129 0",
               done_cyc, obs_op.size(), err_obs, 4 * 64 + 2 + LAT);
    end
  endtask

  task automatic test_wrap();
    seed = $urandom;
    run_job(7'd2, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 0, -1, 0);
    checks++;
    if (req_q.size() != 4 || req_q[0] !== 32'hFFFF_FFF8 || req_q[1] !== 32'hFFFF_FFFC
        || req_q[2] !== 32'hFFFF_FFFC || req_q[3] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr got %0d reqs last %h expected 4 reqs last 00000000",
               req_q.size(), (req_q.size() > 0) ? req_q[req_q.size() - 1] : 32'h0);
    end
  endtask

  task automatic test_bus_err();
    logic [31:0] prev;
    seed = $urandom;
    run_job(7'd1, $urandom, $urandom, 0, -1, 0);
    prev = res_obs;
    run_job(7'd3, 32'h400, 32'h800, 0, 1, 0);
    checks++;
    if (obs_op.size() != 1 || obs_op[0] !== 3'b001 || err_obs !== 1'b1
        || res_obs !== prev || done_cyc != 5 || done_cnt != 1) begin
      errors++;
      $display("FAIL bus_err got strobes %0d err %b res %h done %0d expected 1 1 %h 5",
               obs_op.size(), err_obs, res_obs, done_cyc, prev);
    end
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b expected 1", err_o);
    end
    run_job(7'd1, $urandom, $urandom, 0, -1, 0);
    checks++;
    if (err_obs !== 1'b0 || res_obs !== res_at_done) begin
      errors++;
      $display("FAIL err_clear got err %b res %h expected 0 %h", err_obs, res_obs, res_at_done);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    seed = $urandom;
    run_job(7'd1, $urandom, $urandom, 0, -1, 0);
    @(negedge clk);
    start_i = 1'b1; len_i = 7'd3; base_a_i = 32'h40; base_b_i = 32'h80;
    @(negedge clk);
    start_i = 1'b0;
    data_gnt_i = data_req_o;
    @(negedge clk);
    data_gnt_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      data_rvalid_i = 1'b0;
      if (busy_o || done_o || mmult_en_o || data_req_o || err_o
          || result_o !== 0 || perf_cycles_o !== 0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid got %0d bad cycles (busy %b en %b res %h) expected 0",
               bad, busy_o, mmult_en_o, result_o);
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; len_i = '0;
    base_a_i = '0; base_b_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    data_rdata_i = '0; data_err_i = 1'b0;
    mmult_result_i = '0; seed = '0;
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_dot_product();
    test_gnt_delay();
    test_len_bounds();
    test_wrap();
    test_bus_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
